// File: rtl/sec32_pkg.sv
// Shared constants, types and parity helpers for the 32-bit SEC check-bit encoder.
package sec32_pkg;

   localparam int DATA_W = 32;
   localparam int CHK_W  = 8;
   localparam int CW_W   = DATA_W + CHK_W;
   localparam int NGRP   = DATA_W / 4;
   localparam int NCOL   = 4;
   localparam int POS_W  = 6;

   // Check-bit masks: chk[i] = ^(data & CHK_MASK[i]).
   localparam logic [DATA_W-1:0] CHK_MASK [0:CHK_W-1] = '{
      32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
      32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
   };

   typedef struct packed {
      logic [CHK_W-1:0]  chk;
      logic [DATA_W-1:0] data;
   } cw_t;

   // First-stage payload: the data word, its partial parities and the injection tag.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [NGRP-1:0]   grp;
      logic [NCOL-1:0]   colp;
      logic [NCOL-1:0]   colq;
      logic              tag;
      logic [POS_W-1:0]  pos;
   } s1_t;

   localparam int S1_W = $bits(s1_t);

   // Each mask is one column-parity term (low or high half) plus two nibble
   // groups from the opposite half, so every check bit is a 3-input XOR here.
   function automatic logic [CHK_W-1:0] chk_from_terms(input logic [NGRP-1:0] grp,
                                                       input logic [NCOL-1:0] colp,
                                                       input logic [NCOL-1:0] colq);
      logic [CHK_W-1:0] c;
      c[0] = colp[0] ^ grp[4] ^ grp[5];
      c[1] = colp[1] ^ grp[6] ^ grp[7];
      c[2] = colp[2] ^ grp[4] ^ grp[6];
      c[3] = colp[3] ^ grp[5] ^ grp[7];
      c[4] = colq[0] ^ grp[0] ^ grp[1];
      c[5] = colq[1] ^ grp[2] ^ grp[3];
      c[6] = colq[2] ^ grp[0] ^ grp[2];
      c[7] = colq[3] ^ grp[1] ^ grp[3];
      return c;
   endfunction

endpackage

// File: rtl/sec32_pipe_reg.sv
// One valid/ready register slice; accepts a new beat whenever it is empty or draining.
module sec32_pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         up_valid,
   output logic         up_ready,
   input  logic [W-1:0] up_data,
   output logic         dn_valid,
   input  logic         dn_ready,
   output logic [W-1:0] dn_data
);

   // Loading when the held beat leaves in the same cycle avoids a bubble.
   assign up_ready = !dn_valid || dn_ready;

   // Capture a beat on load; hold valid and data stable while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dn_valid <= 1'b0;
         dn_data  <= '0;
      end else if (up_ready) begin
         dn_valid <= up_valid;
         if (up_valid) begin
            dn_data <= up_data;
         end
      end
   end

endmodule

// File: rtl/sec32_check_encoder.sv
// Streaming SEC check-bit generator: 32-bit words in, {chk, data} codewords out,
// two pipeline stages with full backpressure and one-shot single-bit error injection.
module sec32_check_encoder
   import sec32_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int INJ_EN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CW_W-1:0]   out_cw,
   input  logic              inj_arm,
   input  logic [POS_W-1:0]  inj_pos,
   output logic              inj_armed,
   output logic [CNT_W-1:0]  word_cnt
);

   // Bit mask for the tagged word; positions past the codeword flip nothing.
   function automatic logic [CW_W-1:0] inj_mask(input logic tag, input logic [POS_W-1:0] pos);
      logic [CW_W-1:0] m;
      m = '0;
      if (tag && (pos < POS_W'(CW_W))) begin
         m[pos] = 1'b1;
      end
      return m;
   endfunction

   logic             in_xfer;
   logic             armed;
   logic [POS_W-1:0] arm_pos;
   logic             s1_valid;
   logic             s2_ready;
   s1_t              s1_in;
   s1_t              s1_q;
   cw_t              s2_in;
   cw_t              s2_q;

   assign in_xfer   = in_valid && in_ready;
   assign inj_armed = (INJ_EN != 0) ? armed : 1'b0;
   assign out_cw    = s2_q;

   // Arm state: a transfer consumes the pending arm, a simultaneous arm
   // re-arms for the following word, and re-arming overwrites the position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed <= 1'b0;
      end else begin
         if (in_xfer) begin
            armed <= 1'b0;
         end
         if (inj_arm) begin
            armed <= 1'b1;
         end
      end
   end

   // Injection position is plain data, captured with each arm pulse.
   always_ff @(posedge clk) begin
      if (inj_arm) begin
         arm_pos <= inj_pos;
      end
   end

   // Accepted-word counter, wrapping naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
      end else if (in_xfer) begin
         word_cnt <= word_cnt + 1'b1;
      end
   end

   // ---- stage 1: nibble-group and column parities of the incoming word ----
   always_comb begin
      s1_in      = '0;
      s1_in.data = in_data;
      for (int j = 0; j < NGRP; j++) begin
         s1_in.grp[j] = ^in_data[4*j +: 4];
      end
      for (int m = 0; m < NCOL; m++) begin
         s1_in.colp[m] = in_data[m]      ^ in_data[m + 4]  ^ in_data[m + 8]  ^ in_data[m + 12];
         s1_in.colq[m] = in_data[16 + m] ^ in_data[20 + m] ^ in_data[24 + m] ^ in_data[28 + m];
      end
      s1_in.tag = (INJ_EN != 0) && armed;
      s1_in.pos = arm_pos;
   end

   sec32_pipe_reg #(
      .W(S1_W)
   ) u_s1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (in_valid),
      .up_ready (in_ready),
      .up_data  (s1_in),
      .dn_valid (s1_valid),
      .dn_ready (s2_ready),
      .dn_data  (s1_q)
   );

   // ---- stage 2: fold partial parities into chk and apply injection ----
   always_comb begin
      s2_in      = '0;
      s2_in.data = s1_q.data;
      s2_in.chk  = chk_from_terms(s1_q.grp, s1_q.colp, s1_q.colq);
      s2_in      = s2_in ^ inj_mask(s1_q.tag, s1_q.pos);
   end

   sec32_pipe_reg #(
      .W(CW_W)
   ) u_s2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (s1_valid),
      .up_ready (s2_ready),
      .up_data  (s2_in),
      .dn_valid (out_valid),
      .dn_ready (out_ready),
      .dn_data  (s2_q)
   );

endmodule

// File: tb/tb_sec32_check_encoder.sv
// Scoreboard bench for sec32_check_encoder: directed vectors, backpressure,
// injection, random corrector round-trip, mid-stream reset and counter wrap.
module tb_sec32_check_encoder;
   import sec32_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [39:0] out_cw;
   logic        inj_arm;
   logic [5:0]  inj_pos;
   logic        inj_armed;
   logic [15:0] word_cnt;

   logic        v2;
   logic        rdy2;
   logic        ov2;
   logic [39:0] cw2;
   logic        ia2;
   logic [3:0]  cnt2;

   typedef struct {
      logic [39:0] cw;
      logic [31:0] data;
      bit          corr;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          last_waits;
   bit          m_armed;
   int          m_pos;
   int          m_cnt;
   logic [39:0] held;

   sec32_check_encoder #(.CNT_W(16), .INJ_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_cw(out_cw), .inj_arm(inj_arm),
      .inj_pos(inj_pos), .inj_armed(inj_armed), .word_cnt(word_cnt)
   );

   sec32_check_encoder #(.CNT_W(4), .INJ_EN(1)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_data(32'h0),
      .out_valid(ov2), .out_ready(1'b1), .out_cw(cw2), .inj_arm(1'b0),
      .inj_pos(6'd0), .inj_armed(ia2), .word_cnt(cnt2)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] chk_ref(input logic [31:0] d);
      logic [7:0] c;
      for (int i = 0; i < 8; i++) c[i] = ^(d & CHK_MASK[i]);
      return c;
   endfunction

   // Reference c499-style corrector: syndrome match against each data column.
   function automatic logic [31:0] correct(input logic [39:0] cw);
      logic [7:0]  s;
      logic [7:0]  col;
      logic [31:0] dd;
      dd = cw[31:0];
      s  = cw[39:32] ^ chk_ref(dd);
      if (s != 8'h00) begin
         for (int k = 0; k < 32; k++) begin
            for (int i = 0; i < 8; i++) col[i] = CHK_MASK[i][k];
            if (col == s) dd[k] = ~dd[k];
         end
      end
      return dd;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] d, input logic [39:0] hand, input bit has_hand,
                       input bit corr = 1'b0, input bit arm_now = 1'b0, input logic [5:0] apos = 6'd0);
      int          n;
      bit          accepted;
      exp_t        e;
      logic [39:0] mcw;
      in_data  = d;
      in_valid = 1'b1;
      if (arm_now) begin
         inj_arm = 1'b1;
         inj_pos = apos;
      end
      n = 0;
      accepted = 1'b0;
      while (!accepted && n <= 200) begin
         @(negedge clk);
         if (in_ready) accepted = 1'b1;
         else n++;
      end
      last_waits = n;
      if (!accepted) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: word %h not accepted, in_ready=%b", d, in_ready);
      end else begin
         mcw = {chk_ref(d), d};
         if (m_armed) begin
            if (m_pos < 40) mcw[m_pos] = ~mcw[m_pos];
            m_armed = 1'b0;
         end
         if (arm_now) begin
            m_armed = 1'b1;
            m_pos   = int'(apos);
         end
         e.cw   = has_hand ? hand : mcw;
         e.data = d;
         e.corr = corr;
         sb.push_back(e);
         m_cnt++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      inj_arm  = 1'b0;
   endtask

   task automatic arm(input logic [5:0] pos);
      inj_arm = 1'b1;
      inj_pos = pos;
      @(posedge clk);
      #1;
      inj_arm = 1'b0;
      m_armed = 1'b1;
      m_pos   = int'(pos);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   // Monitor: pop and compare on every output handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got %h, expected no output", out_cw);
         end else begin
            mon_e = sb.pop_front();
            check("out_cw", 64'(out_cw), 64'(mon_e.cw));
            if (mon_e.corr) check("corrected_data", 64'(correct(out_cw)), 64'(mon_e.data));
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      inj_arm = 1'b0; inj_pos = '0; v2 = 1'b0;
      m_armed = 1'b0; m_pos = 0; m_cnt = 0; last_waits = 0; held = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_cw", 64'(out_cw), 64'd0);
      check("rst_inj_armed", 64'(inj_armed), 64'd0);
      check("rst_word_cnt", 64'(word_cnt), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // T1: latency
      send(32'h00000001, 40'h51_00000001, 1'b1);
      check("t1_valid_early", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      check("t1_valid", 64'(out_valid), 64'd1);
      check("t1_cw", 64'(out_cw), 64'h51_00000001);

      // T2: back-to-back vectors
      send(32'hFFFFFFFF, 40'h00_FFFFFFFF, 1'b1);
      send(32'h80000000, 40'h8A_80000000, 1'b1);
      check("t2_no_stall_a", 64'(last_waits), 64'd0);
      send(32'h00000000, 40'h00_00000000, 1'b1);
      check("t2_no_stall_b", 64'(last_waits), 64'd0);
      send(32'h12345678, 40'h85_12345678, 1'b1);
      check("t2_no_stall_c", 64'(last_waits), 64'd0);
      drain();

      // T3: 5-cycle stall during a 4-word burst
      fork
         begin
            send(32'h00000001, 40'h51_00000001, 1'b1);
            send(32'h80000000, 40'h8A_80000000, 1'b1);
            send(32'hFFFFFFFF, 40'h00_FFFFFFFF, 1'b1);
            send(32'h12345678, 40'h85_12345678, 1'b1);
         end
         begin
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #2;
            check("t3_in_ready_low", 64'(in_ready), 64'd0);
            check("t3_out_valid", 64'(out_valid), 64'd1);
            check("t3_held_cw", 64'(out_cw), 64'h51_00000001);
            held = out_cw;
            repeat (2) begin
               @(posedge clk);
               #2;
               check("t3_stable", 64'(out_cw), 64'(held));
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // T4: injection
      arm(6'd35);
      check("t4_armed", 64'(inj_armed), 64'd1);
      send(32'h12345678, 40'h8D_12345678, 1'b1);
      check("t4_consumed", 64'(inj_armed), 64'd0);
      send(32'h12345678, 40'h85_12345678, 1'b1);
      arm(6'd45);
      send(32'h00000001, 40'h51_00000001, 1'b1);
      check("t4_pos45_consumed", 64'(inj_armed), 64'd0);
      arm(6'd3);
      send(32'h00000001, 40'h51_00000009, 1'b1, 1'b0, 1'b1, 6'd36);
      check("t4_coincide_rearmed", 64'(inj_armed), 64'd1);
      send(32'h00000000, 40'h10_00000000, 1'b1);
      arm(6'd0);
      arm(6'd33);
      send(32'h00000000, 40'h02_00000000, 1'b1);
      check("t4_final_armed", 64'(inj_armed), 64'd0);
      drain();

      // T5: random words through the reference corrector
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) arm(6'($urandom_range(0, 31)));
         send($urandom, 40'h0, 1'b0, 1'b1);
      end
      drain();
      check("word_cnt", 64'(word_cnt), 64'(m_cnt[15:0]));

      // T6: reset mid-stream with both stages full and injection armed
      out_ready = 1'b0;
      send(32'h0000000F, 40'h0, 1'b0);
      send(32'hA5A5A5A5, 40'h0, 1'b0);
      arm(6'd7);
      check("t6_pre_valid", 64'(out_valid), 64'd1);
      check("t6_pre_in_ready", 64'(in_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_in_ready", 64'(in_ready), 64'd1);
      check("t6_out_valid", 64'(out_valid), 64'd0);
      check("t6_out_cw", 64'(out_cw), 64'd0);
      check("t6_inj_armed", 64'(inj_armed), 64'd0);
      check("t6_word_cnt", 64'(word_cnt), 64'd0);
      sb.delete();
      m_armed = 1'b0;
      m_cnt = 0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(32'h00000001, 40'h51_00000001, 1'b1);
      drain();

      // Counter wrap on the CNT_W=4 instance
      v2 = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("wrap_cnt5", 64'(cnt2), 64'd5);
      check("wrap_ready", 64'(rdy2), 64'd1);
      repeat (11) @(posedge clk);
      #1;
      v2 = 1'b0;
      check("wrap_cnt0", 64'(cnt2), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("wrap_drained", 64'(ov2), 64'd0);
      check("wrap_cw_zero_word", 64'(cw2), 64'd0);
      check("wrap_no_inj", 64'(ia2), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
